// File: rtl/tnew_pipe_if.sv
// Decode-side inputs and E/M/W stage outputs of the Tnew pipeline.
// stall_cnt is present only when STALL_CNT_EN is defined.
interface tnew_pipe_if;
  logic        stop;
  logic [31:0] instr_D, pc_D;
  logic [4:0]  A3_D;
  logic        RegWr_D;
  logic [1:0]  Tnew_D;

  logic [31:0] instr_E, pc_E, instr_M, pc_M, instr_W, pc_W;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic        RegWr_E, RegWr_M, RegWr_W;
  logic [1:0]  Tnew_E, Tnew_M, Tnew_W;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  modport master (
    output stop, instr_D, pc_D, A3_D, RegWr_D, Tnew_D,
    input  instr_E, pc_E, A3_E, RegWr_E, Tnew_E,
    input  instr_M, pc_M, A3_M, RegWr_M, Tnew_M,
    input  instr_W, pc_W, A3_W, RegWr_W, Tnew_W
`ifdef STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  stop, instr_D, pc_D, A3_D, RegWr_D, Tnew_D,
    output instr_E, pc_E, A3_E, RegWr_E, Tnew_E,
    output instr_M, pc_M, A3_M, RegWr_M, Tnew_M,
    output instr_W, pc_W, A3_W, RegWr_W, Tnew_W
`ifdef STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/tnew_pipe.sv
// D->E->M->W register banks carrying {instr, pc, A3, RegWr, Tnew} for hazard detection.
// Optional STALL_CNT_EN macro adds a free-running count of stalled cycles.
module tnew_pipe (
  input  logic       clk,
  input  logic       reset,
  tnew_pipe_if.slave bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic        rw;
    logic [1:0]  tnew;
  } stage_t;

  stage_t r_e, r_m, r_w;
  stage_t w_e_next, w_m_next, w_w_next;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  always_comb begin
    w_e_next = '0;
    if (!bus.stop) begin
      w_e_next.instr = bus.instr_D;
      w_e_next.pc    = bus.pc_D;
      w_e_next.a3    = bus.A3_D;
      // writes to $0 never produce a result, so they must not look like a hazard
      w_e_next.rw    = bus.RegWr_D & (bus.A3_D != 5'd0);
      w_e_next.tnew  = bus.Tnew_D;
    end
    w_m_next      = r_e;
    w_m_next.tnew = sat_dec(r_e.tnew);
    w_w_next      = r_m;
    w_w_next.tnew = sat_dec(r_m.tnew);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= w_e_next;
      r_m <= w_m_next;
      r_w <= w_w_next;
    end
  end

  assign bus.instr_E = r_e.instr;
  assign bus.pc_E    = r_e.pc;
  assign bus.A3_E    = r_e.a3;
  assign bus.RegWr_E = r_e.rw;
  assign bus.Tnew_E  = r_e.tnew;

  assign bus.instr_M = r_m.instr;
  assign bus.pc_M    = r_m.pc;
  assign bus.A3_M    = r_m.a3;
  assign bus.RegWr_M = r_m.rw;
  assign bus.Tnew_M  = r_m.tnew;

  assign bus.instr_W = r_w.instr;
  assign bus.pc_W    = r_w.pc;
  assign bus.A3_W    = r_w.a3;
  assign bus.RegWr_W = r_w.rw;
  assign bus.Tnew_W  = r_w.tnew;

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_stall_cnt <= '0;
    else if (bus.stop) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_tnew_pipe.sv
// Directed bench for tnew_pipe: reset, lw/jal/addu propagation, bubbles, Tnew saturation,
// $0 writes, mid-stream reset, and the stall counter when STALL_CNT_EN is defined.
module tb_tnew_pipe;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  tnew_pipe_if bus ();

  tnew_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // s: 0 = E, 1 = M, 2 = W
  task automatic chk_stage(input int s, input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [4:0] a3,
                           input logic rw, input logic [1:0] tn);
    logic [31:0] o_instr, o_pc;
    logic [4:0]  o_a3;
    logic        o_rw;
    logic [1:0]  o_tn;
    case (s)
      0: begin o_instr = bus.instr_E; o_pc = bus.pc_E; o_a3 = bus.A3_E; o_rw = bus.RegWr_E; o_tn = bus.Tnew_E; end
      1: begin o_instr = bus.instr_M; o_pc = bus.pc_M; o_a3 = bus.A3_M; o_rw = bus.RegWr_M; o_tn = bus.Tnew_M; end
      default: begin o_instr = bus.instr_W; o_pc = bus.pc_W; o_a3 = bus.A3_W; o_rw = bus.RegWr_W; o_tn = bus.Tnew_W; end
    endcase
    chk({tag, ".instr"}, o_instr, instr);
    chk({tag, ".pc"},    o_pc,    pc);
    chk({tag, ".A3"},    {27'd0, o_a3}, {27'd0, a3});
    chk({tag, ".RegWr"}, {31'd0, o_rw}, {31'd0, rw});
    chk({tag, ".Tnew"},  {30'd0, o_tn}, {30'd0, tn});
  endtask

  task automatic chk_all_zero(input string tag);
    chk_stage(0, {tag, ".E"}, '0, '0, '0, 1'b0, '0);
    chk_stage(1, {tag, ".M"}, '0, '0, '0, 1'b0, '0);
    chk_stage(2, {tag, ".W"}, '0, '0, '0, 1'b0, '0);
`ifdef STALL_CNT_EN
    chk({tag, ".stall_cnt"}, bus.stall_cnt, 32'd0);
`endif
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] a3,
                       input logic rw, input logic [1:0] tn, input logic stp);
    bus.instr_D = instr;
    bus.pc_D    = pc;
    bus.A3_D    = a3;
    bus.RegWr_D = rw;
    bus.Tnew_D  = tn;
    bus.stop    = stp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] LW   = 32'h8C08_0004;
  localparam logic [31:0] JAL  = 32'h0C00_0010;
  localparam logic [31:0] ADDU = 32'h0128_4821;
  localparam logic [31:0] ADD0 = 32'h0000_0021;
  localparam logic [31:0] ORI  = 32'h3405_0007;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(LW, 32'h100, 5'd8, 1'b1, 2'd2, 1'b1);
    #2;
    chk_all_zero("rst_async");
    tick();
    chk_all_zero("rst_edge");

    // lw enters E; reset released between edges
    reset = 1'b0;
    drive(LW, 32'h100, 5'd8, 1'b1, 2'd2, 1'b0);
    tick();
    chk_stage(0, "e1.E_lw", LW, 32'h100, 5'd8, 1'b1, 2'd2);
    chk_stage(1, "e1.M", '0, '0, '0, 1'b0, '0);

    drive(JAL, 32'h104, 5'd31, 1'b1, 2'd0, 1'b0);
    tick();
    chk_stage(0, "e2.E_jal", JAL, 32'h104, 5'd31, 1'b1, 2'd0);
    chk_stage(1, "e2.M_lw",  LW,  32'h100, 5'd8,  1'b1, 2'd1);

    // stall while addu waits in D
    drive(ADDU, 32'h108, 5'd9, 1'b1, 2'd1, 1'b1);
    tick();
    chk_stage(0, "e3.E_bub", '0,  '0,      '0,    1'b0, '0);
    chk_stage(1, "e3.M_jal", JAL, 32'h104, 5'd31, 1'b1, 2'd0);
    chk_stage(2, "e3.W_lw",  LW,  32'h100, 5'd8,  1'b1, 2'd0);

    drive(ADDU, 32'h108, 5'd9, 1'b1, 2'd1, 1'b0);
    tick();
    chk_stage(0, "e4.E_addu", ADDU, 32'h108, 5'd9,  1'b1, 2'd1);
    chk_stage(1, "e4.M_bub",  '0,   '0,      '0,    1'b0, '0);
    chk_stage(2, "e4.W_jal",  JAL,  32'h104, 5'd31, 1'b1, 2'd0);

    drive(ADD0, 32'h10C, 5'd0, 1'b1, 2'd1, 1'b0);
    tick();
    chk_stage(0, "e5.E_r0",   ADD0, 32'h10C, 5'd0, 1'b0, 2'd1);
    chk_stage(1, "e5.M_addu", ADDU, 32'h108, 5'd9, 1'b1, 2'd0);
    chk_stage(2, "e5.W_bub",  '0,   '0,      '0,   1'b0, '0);

    for (int i = 0; i < 3; i++) begin
      drive(ORI, 32'h110 + 32'(4 * i), 5'd5, 1'b1, 2'd1, 1'b0);
      tick();
    end
    chk_stage(0, "full.E", ORI, 32'h118, 5'd5, 1'b1, 2'd1);
    chk_stage(1, "full.M", ORI, 32'h114, 5'd5, 1'b1, 2'd0);
    chk_stage(2, "full.W", ORI, 32'h110, 5'd5, 1'b1, 2'd0);

    // reset between edges, then an edge with reset still high
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    drive(LW, 32'h200, 5'd8, 1'b1, 2'd2, 1'b0);
    tick();
    chk_all_zero("rst_hold");

    reset = 1'b0;
    tick();
    chk_stage(0, "post.E", LW, 32'h200, 5'd8, 1'b1, 2'd2);
    chk_stage(1, "post.M", '0, '0, '0, 1'b0, '0);

`ifdef STALL_CNT_EN
    chk("cnt0", bus.stall_cnt, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(ADDU, 32'h300, 5'd9, 1'b1, 2'd1, (i < 5));
      tick();
    end
    chk("cnt5", bus.stall_cnt, 32'd5);
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    chk("cnt_pre", bus.stall_cnt, 32'hFFFF_FFFF);
    drive(ADDU, 32'h300, 5'd9, 1'b1, 2'd1, 1'b1);
    tick();
    chk("cnt_wrap", bus.stall_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
